push_sw_led_arbiter: RTL and testbench

Controller that arbitrates the two push switches (PUSH_SW_LEFT, PUSH_SW_RIGHT) for control of a shared LED bar. It synchronizes and debounces each switch and detects its rising edge. It queues one press per direction and grants moves round-robin through a small FSM that shifts a single lit LED left or right. It sits between the board switch pins and the LED pins, replacing direct edge-to-LED wiring.

---
 rtl/push_sw_led_arbiter.sv | 146 ++++++++++++++
 tb/tb_push_sw_led_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/push_sw_led_arbiter.sv
// push_sw_led_arbiter
//   Arbitrates the two board push switches for control of a one-hot LED bar.
//   Each switch is synchronized (2 flops), debounced, and edge-detected into a
//   one-cycle pulse. Pulses queue one request per direction; a small FSM grants
//   requests round-robin and shifts the lit LED left (toward MSB) or right.
//
//   Parameters:
//     LED_WIDTH        number of LEDs (>= 2)
//     DEBOUNCE_CYCLES  consecutive mismatching samples needed to flip a level (>= 1)
//     HOLD_CYCLES      busy cycles after each move (>= 1)
//   Ports:
//     clk            system clock, rising edge
//     rstb           asynchronous active-low reset
//     PUSH_SW_LEFT   raw left switch, active high, asynchronous
//     PUSH_SW_RIGHT  raw right switch, active high, asynchronous
//     LED            one-hot LED bar, bit 0 = rightmost
//     BUSY           high for HOLD_CYCLES+1 cycles per grant
//     DROP           one-cycle pulse when a press finds its pending slot full
//   Build option:
//     LED_WRAP_EN    defined: moves rotate at the ends; undefined: moves saturate
module push_sw_led_arbiter #(
  parameter int unsigned LED_WIDTH       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 3
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 PUSH_SW_LEFT,
  input  logic                 PUSH_SW_RIGHT,
  output logic [LED_WIDTH-1:0] LED,
  output logic                 BUSY,
  output logic                 DROP
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HLD_W-1:0] HLD_LOAD = HLD_W'(HOLD_CYCLES);
  localparam logic [HLD_W-1:0] HLD_ONE  = HLD_W'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic PRIO_LEFT  = 1'b0;
  localparam logic PRIO_RIGHT = 1'b1;

  // Channel index 0 = left, 1 = right.
  logic [1:0]       raw;
  logic [1:0]       sync1, sync2;
  logic [1:0]       level, level_d;
  logic [1:0]       pulse;
  logic [CNT_W-1:0] cnt [2];

  logic [1:0]       pend;
  logic [1:0]       grant;
  logic [1:0]       pend_next;
  logic             drop_next;
  logic             prio;
  logic [0:0]       state;
  logic [HLD_W-1:0] hold_cnt;
  logic [LED_WIDTH-1:0] led_next;

  assign raw = {PUSH_SW_RIGHT, PUSH_SW_LEFT};

  // Synchronizer, debounce and rising-edge detect for both switches.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      pulse   <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      pulse   <= level & ~level_d;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= ~level[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Grant selection, pending-flag update and next LED pattern.
  always_comb begin
    grant     = '0;
    led_next  = LED;
    if (state == IDLE) begin
      grant[0] = pend[0] & (~pend[1] | (prio == PRIO_LEFT));
      grant[1] = pend[1] & (~pend[0] | (prio == PRIO_RIGHT));
    end

    // A new pulse always sets the flag, even when the old request is granted now.
    pend_next = pulse | (pend & ~grant);
    drop_next = |(pulse & pend & ~grant);

`ifdef LED_WRAP_EN
    if (grant[0])      led_next = {LED[LED_WIDTH-2:0], LED[LED_WIDTH-1]};
    else if (grant[1]) led_next = {LED[0], LED[LED_WIDTH-1:1]};
`else
    if (grant[0] && !LED[LED_WIDTH-1]) led_next = LED << 1;
    else if (grant[1] && !LED[0])      led_next = LED >> 1;
`endif
  end

  // BUSY is registered from the grant so it covers the grant cycle plus the
  // full hold window, and stays high across back-to-back grants.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pend     <= '0;
      prio     <= PRIO_LEFT;
      state    <= IDLE;
      hold_cnt <= '0;
      LED      <= LED_WIDTH'(1);
      BUSY     <= 1'b0;
      DROP     <= 1'b0;
    end else begin
      pend <= pend_next;
      DROP <= drop_next;
      LED  <= led_next;
      BUSY <= (|grant) | (state == HOLD);
      if (|grant) prio <= grant[0] ? PRIO_RIGHT : PRIO_LEFT;
      case (state)
        IDLE: begin
          if (|grant) begin
            hold_cnt <= HLD_LOAD;
            state    <= HOLD;
          end
        end
        default: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == HLD_ONE) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_push_sw_led_arbiter.sv
module tb_push_sw_led_arbiter;

  localparam int W = 8;
  localparam int D = 2;
  localparam int H = 3;
`ifdef LED_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] led;
    logic         busy;
    logic         drop;
  } exp_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic raw_l = 1'b0;
  logic raw_r = 1'b0;
  logic [W-1:0] led;
  logic busy;
  logic drop;

  push_sw_led_arbiter #(
    .LED_WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .PUSH_SW_LEFT(raw_l),
    .PUSH_SW_RIGHT(raw_r),
    .LED(led),
    .BUSY(busy),
    .DROP(drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  // Reference model state: debounced levels, request flags, grant timer, LED position.
  logic [1:0] rawq[$];
  logic [1:0] win[$];
  logic [1:0] m_lvl, m_lvlp, m_pulse, m_pend;
  int m_prio;   // 0 = left has priority, 1 = right
  int m_wait;   // cycles left before another grant is allowed
  int m_pos;    // index of the lit LED

  int busy_cnt;
  int drop_cnt;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rawq.delete();
    rawq.push_back(2'b00);
    rawq.push_back(2'b00);
    win.delete();
    m_lvl = '0; m_lvlp = '0; m_pulse = '0; m_pend = '0;
    m_prio = 0; m_wait = 0; m_pos = 0;
  endtask

  task automatic model_step(input logic l, input logic r, output exp_t e);
    bit g;
    int gd;
    bit busy_n, drp, cleared, all_diff;
    logic [1:0] s, pend_n;
    g = 0; gd = 0;
    if (m_wait == 0 && m_pend != 2'b00) begin
      g = 1;
      if (m_pend == 2'b11) gd = m_prio;
      else gd = m_pend[0] ? 0 : 1;
    end
    busy_n = g || (m_wait > 0);
    if (g) begin
      m_wait = H;
      if (gd == 0) begin
        if (m_pos < W - 1) m_pos++;
        else if (WRAP) m_pos = 0;
      end else begin
        if (m_pos > 0) m_pos--;
        else if (WRAP) m_pos = W - 1;
      end
      m_prio = (gd == 0) ? 1 : 0;
    end else if (m_wait > 0) begin
      m_wait--;
    end
    drp = 0;
    for (int c = 0; c < 2; c++) begin
      cleared = g && (gd == c);
      if (m_pulse[c] && m_pend[c] && !cleared) drp = 1;
      pend_n[c] = m_pulse[c] | (m_pend[c] & !cleared);
    end
    m_pend  = pend_n;
    m_pulse = m_lvl & ~m_lvlp;
    m_lvlp  = m_lvl;
    // A level flips once the last D synchronized samples all disagree with it.
    s = rawq.pop_front();
    rawq.push_back({r, l});
    win.push_back(s);
    if (win.size() > D) void'(win.pop_front());
    for (int c = 0; c < 2; c++) begin
      if (win.size() == D) begin
        all_diff = 1;
        foreach (win[k]) if (win[k][c] == m_lvl[c]) all_diff = 0;
        if (all_diff) m_lvl[c] = ~m_lvl[c];
      end
    end
    e.led = '0;
    e.led[m_pos] = 1'b1;
    e.busy = busy_n;
    e.drop = drp;
  endtask

  // One clock: drive raw inputs on the falling edge, model the rising edge,
  // queue the expected outputs, then tally BUSY/DROP for segment checks.
  task automatic step(input logic l, input logic r);
    exp_t e;
    @(negedge clk);
    raw_l = l;
    raw_r = r;
    @(posedge clk);
    model_step(l, r, e);
    sb.push_back(e);
    #1;
    busy_cnt += int'(busy);
    drop_cnt += int'(drop);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    raw_l = 1'b0;
    raw_r = 1'b0;
    rstb = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    busy_cnt = 0;
    drop_cnt = 0;
  endtask

  // Monitor: compares every output sample against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (led !== e.led || busy !== e.busy || drop !== e.drop) begin
          errors++;
          $display("FAIL cycle_check at %0t: LED=%h BUSY=%b DROP=%b expected LED=%h BUSY=%b DROP=%b",
                   $time, led, busy, drop, e.led, e.busy, e.drop);
        end
      end
    end
  end

  initial begin
    int hl, hr;
    logic vl, vr;
    logic [9:0] pat_l;
    model_reset();
    busy_cnt = 0;
    drop_cnt = 0;
    #12;
    chk("reset_led", int'(led), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_drop", int'(drop), 0);
    do_reset();

    // Single left press held 5 cycles.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    idle(10);
    chk("left_led", int'(led), 'h02);
    chk("left_busy_cycles", busy_cnt, H + 1);
    chk("left_no_drop", drop_cnt, 0);

    // Glitch shorter than the debounce window.
    busy_cnt = 0;
    step(1'b1, 1'b0);
    idle(10);
    chk("glitch_led", int'(led), 'h02);
    chk("glitch_busy", busy_cnt, 0);

    // Both switches on the same edge: left first, then right.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    idle(15);
    chk("both_led", int'(led), 'h01);
    chk("both_busy_cycles", busy_cnt, 2 * (H + 1));

    // Right move at bit 0: rotate or saturate.
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    idle(10);
    chk("right_edge_led", int'(led), WRAP ? 'h80 : 'h01);
    chk("right_edge_busy", busy_cnt, H + 1);

    // Three quick left presses behind a right request: third is dropped.
    do_reset();
    pat_l = 10'b1100110011;
    for (int i = 0; i < 10; i++) step(pat_l[i], (i < 2) ? 1'b1 : 1'b0);
    idle(20);
    chk("drop_count", drop_cnt, 1);
    chk("drop_led", int'(led), 'h02);

    // Randomized switch activity.
    do_reset();
    hl = 0; hr = 0; vl = 1'b0; vr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (hl == 0) begin vl = 1'($urandom_range(0, 1)); hl = int'($urandom_range(1, 7)); end
      if (hr == 0) begin vr = 1'($urandom_range(0, 1)); hr = int'($urandom_range(1, 7)); end
      hl--; hr--;
      step(vl, vr);
    end
    idle(12);

    // Reset in the middle of a hold window with a right request queued.
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(4);
    chk("pre_reset_busy", int'(busy), 1);
    raw_l = 1'b0;
    raw_r = 1'b0;
    #2;
    rstb = 1'b0;
    #1;
    chk("async_reset_led", int'(led), 1);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_drop", int'(drop), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    busy_cnt = 0;
    idle(12);
    chk("post_reset_led", int'(led), 1);
    chk("post_reset_busy", busy_cnt, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
